// File: rtl/qgemm_basic_operand_fetcher.sv
// AXI4 read master: streams a contiguous block of 32-bit words from the QGEMM SRAM onto a valid/ready operand stream.
// Optional feature macro QGEMM_BASIC_FETCHER_4KB_SPLIT_EN: when defined, bursts never cross a 4 KB address boundary.
`ifndef REQUIRED_BW_OF_SLAVE_TID
`define REQUIRED_BW_OF_SLAVE_TID 4
`endif

module qgemm_basic_operand_fetcher #(
    parameter int BW_ADDR     = 32,
    parameter int BW_DATA     = 32,
    parameter int BW_AXI_TID  = `REQUIRED_BW_OF_SLAVE_TID,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int BW_NUM_WORD = 16
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   start,
    input  logic [BW_ADDR-1:0]     base_addr,
    input  logic [BW_NUM_WORD-1:0] num_word,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [BW_AXI_TID-1:0]  txarid,
    output logic [BW_ADDR-1:0]     txaraddr,
    output logic [7:0]             txarlen,
    output logic [2:0]             txarsize,
    output logic [1:0]             txarburst,
    output logic                   txarvalid,
    input  logic                   txarready,
    input  logic [BW_AXI_TID-1:0]  txrid,
    input  logic [BW_DATA-1:0]     txrdata,
    input  logic [1:0]             txrresp,
    input  logic                   txrlast,
    input  logic                   txrvalid,
    output logic                   txrready,
    output logic [BW_DATA-1:0]     oq_data,
    output logic                   oq_valid,
    input  logic                   oq_ready
);
    localparam int BW_PTR = $clog2(FIFO_DEPTH);
    localparam int BW_CNT = BW_PTR + 1;
    localparam logic [BW_CNT-1:0]      DEPTH_CNT = BW_CNT'(FIFO_DEPTH);
    localparam logic [BW_NUM_WORD-1:0] BURST_CAP = BW_NUM_WORD'(BURST_LEN);
    localparam logic [BW_NUM_WORD-1:0] ONE_WORD  = BW_NUM_WORD'(1);
    localparam logic [BW_PTR-1:0]      ONE_PTR   = BW_PTR'(1);
    localparam logic [BW_CNT-1:0]      ONE_CNT   = BW_CNT'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, RECV, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [BW_ADDR-1:0]     addr_reg, addr_next;
    logic [BW_NUM_WORD-1:0] remaining_reg, remaining_next;
    logic [BW_NUM_WORD-1:0] burst_reg, burst_next;
    logic [BW_NUM_WORD-1:0] beat_reg, beat_next;
    logic                   error_reg, error_next;

    logic [BW_DATA-1:0]     mem [FIFO_DEPTH];
    logic [BW_PTR-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [BW_CNT-1:0]      count_reg;
    logic                   push, pop;

    logic [BW_NUM_WORD-1:0] beats;
    logic [BW_NUM_WORD-1:0] free_words;
    logic                   last_beat;
    logic                   unused_inputs;

`ifdef QGEMM_BASIC_FETCHER_4KB_SPLIT_EN
    logic [BW_NUM_WORD-1:0] to_boundary;
    assign to_boundary = BW_NUM_WORD'(11'd1024 - {1'b0, addr_reg[11:2]});
`endif

    always_comb begin
        beats = (remaining_reg < BURST_CAP) ? remaining_reg : BURST_CAP;
`ifdef QGEMM_BASIC_FETCHER_4KB_SPLIT_EN
        if (to_boundary < beats) begin
            beats = to_boundary;
        end
`endif
    end

    assign free_words = BW_NUM_WORD'(DEPTH_CNT - count_reg);
    assign last_beat  = (beat_reg == burst_reg - ONE_WORD);
    assign push       = (state_reg == RECV) && txrvalid;
    assign pop        = oq_valid && oq_ready;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        burst_next     = burst_reg;
        beat_next      = beat_reg;
        error_next     = error_reg;
        txarvalid      = 1'b0;
        txrready       = 1'b0;
        done           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next      = {base_addr[BW_ADDR-1:2], 2'b00};
                    remaining_next = num_word;
                    error_next     = 1'b0;
                    state_next     = (num_word == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                // Only ask for a burst the FIFO can swallow whole, so R never stalls.
                txarvalid = (free_words >= beats);
                if (txarvalid && txarready) begin
                    addr_next      = addr_reg + BW_ADDR'({beats, 2'b00});
                    remaining_next = remaining_reg - beats;
                    burst_next     = beats;
                    beat_next      = '0;
                    state_next     = RECV;
                end
            end
            RECV: begin
                txrready = 1'b1;
                if (txrvalid) begin
                    beat_next = beat_reg + ONE_WORD;
                    if (txrresp != 2'b00 || txrlast != last_beat) begin
                        error_next = 1'b1;
                    end
                    if (last_beat) begin
                        state_next = (remaining_reg == '0) ? DRAIN : ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (count_reg == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstnn) begin
        if (rstnn) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            burst_reg     <= '0;
            beat_reg      <= '0;
            error_reg     <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            burst_reg     <= burst_next;
            beat_reg      <= beat_next;
            error_reg     <= error_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + ONE_CNT;
                2'b01:   count_reg <= count_reg - ONE_CNT;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= txrdata;
        end
    end

    assign oq_valid  = (count_reg != '0);
    assign oq_data   = mem[rd_ptr_reg];
    assign busy      = (state_reg != IDLE);
    assign error     = error_reg;
    assign txarid    = '0;
    assign txaraddr  = addr_reg;
    assign txarlen   = (state_reg == ISSUE) ? 8'(beats - ONE_WORD) : 8'd0;
    assign txarsize  = 3'd2;
    assign txarburst = 2'b01;

    assign unused_inputs = ^{txrid, base_addr[1:0]};

endmodule

// File: doc/qgemm_basic_operand_fetcher.md
# qgemm_basic_operand_fetcher

AXI4 read master that streams a contiguous block of 32-bit operand words out of the QGEMM local SRAM slave and delivers them, in address order, on a valid/ready stream to the QGEMM compute array. It sits directly downstream of the SRAM's AXI read channels. It splits a transfer into INCR bursts and issues a burst only when its internal FIFO can absorb the whole burst, so the read channel never back-pressures the SRAM.

## Interface
- BW_ADDR, 32, AXI address width
- BW_DATA, 32, data/word width (fixed 32; SIZE=2)
- BW_AXI_TID, `REQUIRED_BW_OF_SLAVE_TID`, AXI ID width; all ARs use ID 0
- BURST_LEN, 16, max beats per burst (1..256)
- FIFO_DEPTH, 32, output FIFO entries; must be ≥ BURST_LEN, power of 2
- BW_NUM_WORD, 16, width of transfer length

- clk  in  1  clock
- rstnn  in  1  reset; asynchronous, active-high (asserted = 1), despite the codebase name
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  BW_ADDR  byte address of first word; bits [1:0] ignored (treated as 0)
- num_word  in  BW_NUM_WORD  words to fetch
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last word leaves the stream
- error  out  1  sticky; cleared on next accepted start
- txarid/txaraddr/txarlen/txarsize/txarburst  out  AXI widths  AR payload; size=2, burst=INCR
- txarvalid  out  1 / txarready  in  1  AR handshake
- txrid  in  BW_AXI_TID / txrdata  in  BW_DATA / txrresp  in  2 / txrlast  in  1  R payload
- txrvalid  in  1 / txrready  out  1  R handshake
- oq_data  out  BW_DATA  operand word
- oq_valid  out  1 / oq_ready  in  1  output stream handshake

## Operation
- States: IDLE, ISSUE, RECV, DRAIN.
- IDLE: start=1 latches addr/remaining, clears error, sets busy. If num_word=0, go to DRAIN (done next cycle, no AR). Otherwise go to ISSUE.
- ISSUE: beats = min(BURST_LEN, remaining, words to next 4 KB boundary [macro]).
  - txarvalid asserts only when FIFO free entries ≥ beats, with txarlen=beats-1.
  - Payload is held stable until txarready. On handshake: addr += 4·beats, remaining -= beats, go to RECV.
- RECV: txrready=1 (space reserved). Each beat is written to the FIFO; txrresp≠OKAY sets error.
  - A beat counter tracks the burst; txrlast must coincide with the final beat, otherwise error is set. The burst still ends on the counter, not on txrlast.
  - End of burst: go to ISSUE if remaining>0, else DRAIN.
- Exactly one outstanding burst; no AR is issued during RECV.
- DRAIN: wait for FIFO empty, then pulse done for one cycle, drop busy, go to IDLE.
- start outside IDLE is ignored.
- FIFO: simultaneous push and pop on a full FIFO is legal. Occupancy counter width is log2(FIFO_DEPTH)+1. Pointers wrap naturally.
- Reset mid-operation returns everything to IDLE/empty. In-flight AXI transactions are abandoned; the system reset covers the slave.

## Timing
- Reset values: busy=0, done=0, error=0, txarvalid=0, txrready=0, oq_valid=0, txaraddr=0, txarlen=0. txarsize=2 and txarburst=INCR are constant.
- start → txarvalid: 1 cycle if FIFO space is available.
- R beat accepted at cycle n → oq_valid at n+1 (registered FIFO, no bypass).
- done asserts the cycle after the pop that empties the FIFO in DRAIN.
- Full throughput: with oq_ready=1 and FIFO_DEPTH ≥ 2·BURST_LEN, the next AR issues the cycle after the previous rlast.

## Configuration
- QGEMM_BASIC_FETCHER_4KB_SPLIT_EN
  - Defined: bursts are truncated so no burst crosses a 4 KB address boundary.
  - Undefined: bursts are min(BURST_LEN, remaining) regardless of alignment; software guarantees alignment.

## Test plan
- base=0x100, num_word=40, BURST_LEN=16, oq_ready=1 → ARs at 0x100/len15, 0x140/len15, 0x180/len7; 40 words out in order; one done pulse.
- num_word=0 → no txarvalid; done pulse 1 cycle after start; busy high one cycle.
- Macro defined, base=0xFF8, num_word=8 → ARs 0xFF8/len1, 0x1000/len5. Macro undefined → a single AR 0xFF8/len7.
- oq_ready=0, FIFO_DEPTH=32, num_word=64 → two bursts of 16 issued, third AR withheld until ≥16 words are popped; no data lost.
- Slave returns SLVERR on beat 3 of burst 1 → error=1 sticky; all words still delivered; the next start clears error.
- Assert rstnn during RECV → all outputs at reset values next cycle; a new start after release completes normally.
